// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing {c_out, s} = a + b + c_in, LSB first,
// one bit per clock through a single 1-bit full-adder cell.
//
// Parameters:
//   WIDTH  operand/sum width in bits (2..32)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    synchronous active-high reset
//   start  begin an addition (sampled only when idle)
//   a, b   operands, captured on the accepting edge
//   c_in   initial carry, captured on the accepting edge
//   busy   high while bits are being added
//   done   one-cycle pulse when s/c_out are final
//   s      sum register, holds the last result until the next operation shifts in
//   c_out  carry out of the MSB, held with s
//   ovf    (only with SERIAL_ADDER_OVF_EN defined) signed overflow of the result,
//          i.e. carry into MSB XOR carry out of MSB, held with s
//
// Configuration macro: SERIAL_ADDER_OVF_EN adds the ovf output and its register.

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Wide enough to count up to WIDTH so the counter never wraps.
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;

   logic sum_bit;
   logic carry_bit;
   logic last_bit;

   // The single full-adder cell.
   assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         c_out   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= c_in;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               // Sum bits enter from the MSB side so bit 0 ends up at s[0].
               s       <= {sum_bit, s[WIDTH-1:1]};
               c_out   <= carry_bit;
               carry_q <= carry_bit;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_q is the carry into the MSB on this final step.
                  ovf     <= carry_q ^ carry_bit;
`endif
               end
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed vector table, hand-written
// sequences for abort/ignore/back-to-back behaviour, and a random sweep
// against a+b+c_in. Works with or without SERIAL_ADDER_OVF_EN.

module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      logic         ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // busy and done must never be high together.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (busy === 1'b1 && done === 1'b1) begin
            errors++;
            $display("FAIL busy_done_exclusive: busy=1 done=1 expected not both");
         end
      end
   end

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic [W-1:0] es, input logic ec,
                         input logic eo);
      int cyc;
      a     = av;
      b     = bv;
      c_in  = cv;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_busy"}, 32'(busy), 32'd1);
      wait_done(cyc);
      chk({name, "_latency"}, 32'(cyc), 32'(W));
      chk({name, "_s"}, 32'(s), 32'(es));
      chk({name, "_cout"}, 32'(c_out), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"}, 32'(ovf), 32'(eo));
`endif
      tick();
      chk({name, "_idle_done"}, 32'(done), 32'd0);
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
      chk({name, "_hold_s"}, 32'(s), 32'(es));
   endtask

   initial begin
      int           cyc;
      int           busy_cnt;
      int           done_at[$];
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         cv;
      logic [W:0]   full;
      logic [W-1:0] low;
      logic         cm;

      //        a      b      cin   s      c     ovf
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
      vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[9] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

      // Reset with start asserted: start must be ignored.
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'hA5;
      b     = 8'h5A;
      c_in  = 1'b1;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("idle_after_rst", 32'(busy), 32'd0);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].s, vecs[i].c, vecs[i].ovf);
      end

      // Start re-pulsed 3 cycles into RUN with different operands: ignored.
      a     = 8'h5A;
      b     = 8'h3C;
      c_in  = 1'b0;
      start = 1'b1;
      tick();
      start    = 1'b0;
      busy_cnt = 0;
      cyc      = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) busy_cnt++;
         if (cyc == 3) begin
            a     = 8'hFF;
            b     = 8'hFF;
            c_in  = 1'b1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      chk("ign_busy_cycles", 32'(busy_cnt), 32'd8);
      chk("ign_s", 32'(s), 32'h96);
      chk("ign_cout", 32'(c_out), 32'd0);
      tick();
      chk("ign_no_queue0", 32'(busy), 32'd0);
      tick();
      chk("ign_no_queue1", 32'(busy), 32'd0);

      // Reset mid-run (after 4 RUN edges) discards the operation.
      a     = 8'h12;
      b     = 8'h34;
      c_in  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_cout", 32'(c_out), 32'd0);
      tick();
      chk("abort_stays_idle", 32'(busy), 32'd0);
      run_op("after_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

      // Start held high: one accept every W+2 cycles.
      a     = 8'hAA;
      b     = 8'h55;
      c_in  = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 35; i++) begin
         tick();
         if (done === 1'b1) begin
            done_at.push_back(i);
            chk("b2b_s", 32'(s), 32'h00);
            chk("b2b_cout", 32'(c_out), 32'd1);
         end
      end
      start = 1'b0;
      chk("b2b_done_count", 32'(done_at.size()), 32'd3);
      if (done_at.size() >= 3) begin
         chk("b2b_first_done", 32'(done_at[0]), 32'(W));
         chk("b2b_period0", 32'(done_at[1] - done_at[0]), 32'(W + 2));
         chk("b2b_period1", 32'(done_at[2] - done_at[1]), 32'(W + 2));
      end
      wait_done(cyc);
      tick();
      tick();

      // Random sweep against a+b+c_in.
      for (int i = 0; i < 1000; i++) begin
         av   = W'($urandom);
         bv   = W'($urandom);
         cv   = 1'($urandom_range(1, 0));
         full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
         low  = {1'b0, av[W-2:0]} + {1'b0, bv[W-2:0]} + {{(W-1){1'b0}}, cv};
         cm   = low[W-1];
         run_op("rand", av, bv, cv, full[W-1:0], full[W], cm ^ full[W]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
